// File: rtl/input_debounce_if.sv
// ============================================================================
// Module      : input_debounce_if
// Description : Signal bundle between a raw input source and input_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface input_debounce_if;
    logic       din;
    logic       clr_glitch;
    logic       dout;
    logic       busy;
    logic       glitch;
    logic [7:0] glitch_cnt;

    modport master (
        output din,
        output clr_glitch,
        input  dout,
        input  busy,
        input  glitch,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  clr_glitch,
        output dout,
        output busy,
        output glitch,
        output glitch_cnt
    );
endinterface

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// Module      : input_debounce
// Description : Two-flop synchroniser plus stability-qualifying FSM producing
//               a clean level, with bounce reporting and a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce #(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_W         = 8,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input_debounce_if.slave  bus
);

    localparam logic [1:0]       c_STABLE_LO   = 2'd0;
    localparam logic [1:0]       c_WAIT_HI     = 2'd1;
    localparam logic [1:0]       c_STABLE_HI   = 2'd2;
    localparam logic [1:0]       c_WAIT_LO     = 2'd3;
    localparam logic [1:0]       c_RESET_STATE = INIT_LEVEL ? c_STABLE_HI : c_STABLE_LO;
    localparam logic [CNT_W-1:0] c_CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       c_GCNT_MAX    = 8'hFF;

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_glitch;
    logic [7:0]       r_glitch_cnt;
    logic             w_abort;
    logic             w_accept;
    logic             w_cnt_inc;
    logic             w_busy;

    // Synchroniser: only r_s2 is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= INIT_LEVEL;
            r_s2 <= INIT_LEVEL;
        end else begin
            r_s1 <= bus.din;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_STABLE_LO: begin
                if (r_s2) begin
                    w_next_state = c_WAIT_HI;
                end
            end
            c_WAIT_HI: begin
                if (!r_s2) begin
                    w_next_state = c_STABLE_LO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_STABLE_HI;
                end
            end
            c_STABLE_HI: begin
                if (!r_s2) begin
                    w_next_state = c_WAIT_LO;
                end
            end
            c_WAIT_LO: begin
                if (r_s2) begin
                    w_next_state = c_STABLE_HI;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_STABLE_LO;
                end
            end
            default: begin
                w_next_state = c_RESET_STATE;
            end
        endcase
    end

    always_comb begin
        w_abort   = 1'b0;
        w_accept  = 1'b0;
        w_cnt_inc = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            c_WAIT_HI: begin
                w_busy    = 1'b1;
                w_abort   = !r_s2;
                w_accept  = r_s2 && (r_cnt == c_CNT_LAST);
                w_cnt_inc = r_s2 && (r_cnt != c_CNT_LAST);
            end
            c_WAIT_LO: begin
                w_busy    = 1'b1;
                w_abort   = r_s2;
                w_accept  = !r_s2 && (r_cnt == c_CNT_LAST);
                w_cnt_inc = !r_s2 && (r_cnt != c_CNT_LAST);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Clearing on every state change keeps the counter from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= INIT_LEVEL;
        end else if (w_accept) begin
            r_dout <= (r_state == c_WAIT_HI);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch <= 1'b0;
        end else begin
            r_glitch <= w_abort;
        end
    end

    // Clear wins over a coincident abort; the pulse itself is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= 8'd0;
        end else if (bus.clr_glitch) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_abort && (r_glitch_cnt != c_GCNT_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.busy       = w_busy;
    assign bus.glitch     = r_glitch;
    assign bus.glitch_cnt = r_glitch_cnt;

endmodule

`default_nettype wire

// File: doc/input_debounce.md
# input_debounce

Synchronises and debounces one raw asynchronous input (button/switch) and presents a clean, glitch-free level to the edge-detector stage immediately downstream. That stage's level input takes `dout` directly, so every rise/fall it reports corresponds to a stable, filtered transition. It also reports filter activity (`busy`) and rejected bounces (`glitch`, saturating `glitch_cnt`) for debug and status registers.

## Interface
- `STABLE_CYCLES`, default 16: consecutive synchronised samples at the new level needed to accept a transition. Must be at least 1.
- `CNT_W`, default 8: stability-counter width. Requires `2**CNT_W > STABLE_CYCLES-1`.
- `INIT_LEVEL`, default 1'b0: level of the synchroniser, state and `dout` after reset.
- `clk`  input  1: single system clock, all logic on posedge.
- `rst_n`  input  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `din`  input  1: raw asynchronous input, unsynchronised.
- `clr_glitch`  input  1: synchronous clear of `glitch_cnt`.
- `dout`  output  1: debounced level, registered. Feeds the edge detector's level input.
- `busy`  output  1: high while a candidate transition is being qualified.
- `glitch`  output  1: one-cycle registered pulse when a candidate transition is aborted.
- `glitch_cnt`  output  8: count of aborted transitions, saturating at 255.

## Operation
- **Synchroniser:** two flops, `s1 <= din`, `s2 <= s1`. The FSM and counter act only on `s2`.
- **FSM states:** STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Reset enters STABLE_HI if INIT_LEVEL=1, otherwise STABLE_LO.
- **STABLE_LO:**
  - `s2`=1: go to WAIT_HI, `cnt`<=0.
  - Otherwise stay.
- **WAIT_HI:**
  - `s2`=0: go to STABLE_LO, pulse `glitch`, `cnt`<=0.
  - `s2`=1 and `cnt`==STABLE_CYCLES-1: go to STABLE_HI, `dout`<=1, `cnt`<=0.
  - `s2`=1 otherwise: `cnt`<=`cnt`+1.
- **STABLE_HI / WAIT_LO:** mirror images of the two states above, with levels inverted.
- **`dout`:** changes only on WAIT_HI→STABLE_HI or WAIT_LO→STABLE_LO. It never toggles during WAIT states.
- **`busy`:** equals (state==WAIT_HI or state==WAIT_LO), decoded from the registered state.
- **`glitch`:** registered. It is high for exactly the cycle after the edge on which the abort transition occurs.
- **`glitch_cnt`:** increments by 1 on each abort and holds at 255.
  - `clr_glitch` clears it to 0.
  - `clr_glitch` has priority: if it coincides with an abort, the count becomes 0.
  - The `glitch` pulse itself still fires.
- **Arithmetic:** `cnt` is unsigned, `CNT_W` bits. It never wraps, because it is reset on every state change.

## Timing
- **Reset values (while `rst_n`=0, asynchronously):**
  - `s1`=`s2`=`dout`=INIT_LEVEL.
  - `cnt`=0, `busy`=0, `glitch`=0, `glitch_cnt`=0.
  - State is STABLE_LO or STABLE_HI per INIT_LEVEL.
- **Latency:** `din` changes before edge 0 and then holds.
  - `s2` takes the new value at edge 1.
  - The state enters WAIT at edge 2.
  - `dout` changes at edge STABLE_CYCLES+2.
  - Total: N+2 cycles; with N=4, `dout` changes at edge 6.
- **Stability requirement:** `s2` must hold the new level for STABLE_CYCLES+1 consecutive samples. Any contrary sample aborts and restarts from the stable state.
- **STABLE_CYCLES=1:** the WAIT state lasts exactly one cycle, giving 3-cycle latency.
- **Bounce at the final count:** a contrary `s2` on the cycle `cnt`==N-1 aborts. The transition is not accepted.
- **Reset mid-WAIT:** the qualification is abandoned. No `glitch` pulse, no count increment, `dout` returns to INIT_LEVEL.
- **Deassertion of `rst_n`:** the first active edge behaves like any other cycle.

## Test plan
- **Reset:** INIT_LEVEL=0, assert `rst_n`=0 mid-run with `din`=1 -> `dout`=0, `busy`=0, `glitch`=0 and `glitch_cnt`=0 immediately (asynchronously).
- **Clean rise:** N=4, `din` 0→1 before edge 0 and held -> `busy`=1 from edge 2 to edge 5, `dout`=1 after edge 6, `busy`=0 after edge 6, no `glitch`.
- **Bounce:** N=4, `din` high for 3 cycles then low -> `dout` stays 0; one `glitch` pulse; `glitch_cnt`=1; state back to STABLE_LO.
- **Clean fall:** from `dout`=1, `din`→0 held -> `dout`=0 after edge 6 relative to the change; a single fall seen by the edge detector.
- **Reset mid-WAIT:** N=16, `rst_n` pulsed low at `cnt`=8 -> no `glitch`, `glitch_cnt` unchanged at 0, `dout`=INIT_LEVEL.
- **Counter limits:**
  - 300 bounces -> `glitch_cnt`=255.
  - `clr_glitch` coincident with an abort -> `glitch_cnt`=0 while `glitch` still pulses.
